// File: rtl/fsgnj_arbiter_if.sv
// Handshake bundle for the two-requester sign-injection arbiter.
// The master side drives the requests and res_ready; the slave side is the arbiter.
interface fsgnj_arbiter_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_x1, req0_x2;
  logic [1:0]       req0_op;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_x1, req1_x2;
  logic [1:0]       req1_op;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid, res_ready;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;
  logic             res_src, res_err;
  logic [CNT_W-1:0] cnt0, cnt1;

  modport master (
    output req0_valid, req0_x1, req0_x2, req0_op, req0_tag,
    output req1_valid, req1_x1, req1_x2, req1_op, req1_tag,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_y, res_tag, res_src, res_err, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_x1, req0_x2, req0_op, req0_tag,
    input  req1_valid, req1_x1, req1_x2, req1_op, req1_tag,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_y, res_tag, res_src, res_err, cnt0, cnt1
  );
endinterface

// File: rtl/fsgnj_arbiter.sv
// Round-robin arbiter between two requesters feeding a single-stage FSGNJ/N/X unit
// with a skid-free result register and saturating per-requester grant counters.

module fsgnj_lane (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic [31:0] y,
  output logic        err
);
  // Pure bit manipulation: NaN payloads, -0, inf and denormals pass untouched.
  always_comb begin
    y   = x1;
    err = 1'b0;
    case (op)
      2'b00:   y[31] = x2[31];
      2'b01:   y[31] = ~x2[31];
      2'b10:   y[31] = x1[31] ^ x2[31];
      default: err   = 1'b1;
    endcase
  end
endmodule

module fsgnj_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rstn,
  fsgnj_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             vld, gnt;
  logic [NUM_REQ-1:0][31:0]       lane_y;
  logic [NUM_REQ-1:0]             lane_err;
  logic [NUM_REQ-1:0][CNT_W-1:0]  cnt;

  logic             prio, adv, gsrc;
  logic             res_valid, res_src, res_err;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;

  assign req[0] = {bus.req0_x1, bus.req0_x2, bus.req0_op, bus.req0_tag};
  assign req[1] = {bus.req1_x1, bus.req1_x2, bus.req1_op, bus.req1_tag};
  assign vld    = {bus.req1_valid, bus.req0_valid};

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      fsgnj_lane u_lane (
        .x1  (req[i].x1),
        .x2  (req[i].x2),
        .op  (req[i].op),
        .y   (lane_y[i]),
        .err (lane_err[i])
      );
    end
  endgenerate

  assign adv = !res_valid || bus.res_ready;

  // Ready is a pure function of valids, result-register state and prio;
  // rstn gating keeps both readies low while reset is held.
  always_comb begin
    gnt = '0;
    if (rstn && adv) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  assign gsrc = gnt[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_tag   <= '0;
      res_src   <= 1'b0;
      res_err   <= 1'b0;
      prio      <= 1'b0;
    end else if (|gnt) begin
      res_valid <= 1'b1;
      res_y     <= lane_y[gsrc];
      res_tag   <= req[gsrc].tag;
      res_src   <= gsrc;
      res_err   <= lane_err[gsrc];
      prio      <= ~gsrc;
    end else if (adv) begin
      res_valid <= 1'b0;
    end
  end

  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_cnt
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          cnt[i] <= '0;
        else if (gnt[i] && cnt[i] != {CNT_W{1'b1}})
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  endgenerate

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.res_valid  = res_valid;
  assign bus.res_y      = res_y;
  assign bus.res_tag    = res_tag;
  assign bus.res_src    = res_src;
  assign bus.res_err    = res_err;
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];
endmodule
